// File: rtl/bitwise_ops_pkg.sv
// -----------------------------------------------------------------------------
// bitwise_ops_pkg
// Shared definitions for the bitwise_operations block: the 2-bit operation
// select type, its four named codes and the default operand width.
// -----------------------------------------------------------------------------
package bitwise_ops_pkg;

   // Default operand / result width in bits.
   localparam int DEFAULT_WIDTH = 7;

   // Operation select. Kept as a plain 2-bit logic vector rather than an
   // enum so that X/Z on the select can propagate into the ALU's default
   // branch in simulation.
   typedef logic [1:0] op_t;

   localparam op_t OP_AND = 2'b00;  // a & b
   localparam op_t OP_OR  = 2'b01;  // a | b
   localparam op_t OP_XOR = 2'b10;  // a ^ b
   localparam op_t OP_NOT = 2'b11;  // ~a, b ignored

endpackage : bitwise_ops_pkg

// File: rtl/bitwise_alu_core.sv
// -----------------------------------------------------------------------------
// bitwise_alu_core
// Purely combinational bitwise ALU. Every operation acts per bit position;
// there are no carries or cross-bit paths.
//
// Ports
//   a      [WIDTH-1:0]  in   operand A
//   b      [WIDTH-1:0]  in   operand B (ignored for OP_NOT)
//   op     [1:0]        in   operation select (see bitwise_ops_pkg)
//   result [WIDTH-1:0]  out  f(a, b, op)
// -----------------------------------------------------------------------------
module bitwise_alu_core
   import bitwise_ops_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         // Only reachable when op carries X/Z in simulation: force a clean
         // zero instead of letting unknowns spread into the result register.
         default: result = '0;
      endcase
   end

endmodule : bitwise_alu_core

// File: rtl/bitwise_operations.sv
// -----------------------------------------------------------------------------
// bitwise_operations
// Registered bitwise ALU. A new result is computed from a, b and op on every
// rising clock edge and presented on q one cycle later. There is no enable
// and no valid/ready handshake: every edge produces a result, so q is always
// the function of the inputs sampled at the previous edge (or zero after
// reset).
//
// Ports
//   clk                 in   rising-edge clock
//   rst                 in   synchronous active-high reset
//   a    [WIDTH-1:0]    in   operand A
//   b    [WIDTH-1:0]    in   operand B
//   op   [1:0]          in   00 AND, 01 OR, 10 XOR, 11 NOT a
//   q    [WIDTH-1:0]    out  registered result
//   zero                out  registered "result is all zeros" flag
//                            (only when BITWISE_ZERO_FLAG_EN is defined)
//
// Configuration
//   BITWISE_ZERO_FLAG_EN  define to add the registered zero output.
// -----------------------------------------------------------------------------
module bitwise_operations
   import bitwise_ops_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] q
`ifdef BITWISE_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   bitwise_alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (a),
      .b      (b),
      .op     (op),
      .result (q_d)
   );

   // Reset wins over the freshly computed value at the same edge, so an
   // in-flight result is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

`ifdef BITWISE_ZERO_FLAG_EN
   logic zero_d;
   logic zero_q;

   // Derived from the value being loaded, not from q_q, so the flag lines up
   // with q in the same cycle.
   assign zero_d = (q_d == '0);

   // Reset loads q with zeros, so the flag reads 1 to stay consistent.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b1;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign zero = zero_q;
`endif

endmodule : bitwise_operations

// File: tb/tb_bitwise_operations.sv
// -----------------------------------------------------------------------------
// tb_bitwise_operations
// Driver applies inputs on the falling edge and pushes the expected response
// for the following rising edge into exp_q. A separate monitor pops one entry
// after every rising edge, compares q (and zero when built with
// BITWISE_ZERO_FLAG_EN), then re-checks that q still holds after the inputs
// have changed on the next falling edge.
// -----------------------------------------------------------------------------
module tb_bitwise_operations;

   localparam int W = 7;

   logic         clk;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   op;
   logic [W-1:0] q;
`ifdef BITWISE_ZERO_FLAG_EN
   logic         zero;
`endif

   int checks = 0;
   int errors = 0;

   // Each entry packs {expected zero flag, expected q}.
   logic [W:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1);
   end

   // ---------------- DUT ----------------
   bitwise_operations #(
      .WIDTH (W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .op   (op),
      .q    (q)
`ifdef BITWISE_ZERO_FLAG_EN
      ,
      .zero (zero)
`endif
   );

   // ---------------- reference model ----------------
   // Each op is described by its 2-input truth table, indexed by {a_bit, b_bit}.
   // The result is built one bit position at a time from that table.
   function automatic logic [W:0] model(input logic r, input logic [W-1:0] av,
                                        input logic [W-1:0] bv, input logic [1:0] opv);
      logic [3:0]   tt;
      logic [W-1:0] res;
      if (r) return {1'b1, {W{1'b0}}};
      case (opv)
         2'd0:    tt = 4'b1000;   // only 11 -> 1
         2'd1:    tt = 4'b1110;   // anything but 00 -> 1
         2'd2:    tt = 4'b0110;   // 01 and 10 -> 1
         default: tt = 4'b0011;   // a_bit == 0 -> 1, b ignored
      endcase
      res = '0;
      for (int i = 0; i < W; i++) res[i] = tt[{av[i], bv[i]}];
      return {(res == 0), res};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [1:0] opv);
      @(negedge clk);
      rst = r;
      a   = av;
      b   = bv;
      op  = opv;
      exp_q.push_back(model(r, av, bv, opv));
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W:0]   e;
      logic [W-1:0] held;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (q !== e[W-1:0]) begin
               errors++;
               $display("FAIL q_result t=%0t got %b required %b", $time, q, e[W-1:0]);
            end
`ifdef BITWISE_ZERO_FLAG_EN
            checks++;
            if (zero !== e[W]) begin
               errors++;
               $display("FAIL zero_flag t=%0t got %b required %b", $time, zero, e[W]);
            end
`endif
            held = e[W-1:0];
            @(negedge clk);
            #1;
            checks++;
            if (q !== held) begin
               errors++;
               $display("FAIL q_hold t=%0t got %b required %b", $time, q, held);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] rot[4];
      int         wait_cycles;
      rot[0] = 2'b00; rot[1] = 2'b01; rot[2] = 2'b11; rot[3] = 2'b10;

      rst = 1'b1;
      a   = '0;
      b   = '0;
      op  = 2'b00;

      // Reset held for two edges with all-ones operands, then first result.
      drive(1'b1, 7'h7F, 7'h7F, 2'b00);
      drive(1'b1, 7'h7F, 7'h7F, 2'b00);
      drive(1'b0, 7'h7F, 7'h7F, 2'b00);

      // Directed op sequence 00 -> 01 -> 11 -> 10.
      for (int i = 0; i < 4; i++) drive(1'b0, 7'b1010101, 7'b0110011, rot[i]);

      // Zero flag: complementary operands.
      drive(1'b0, 7'b1010101, 7'b0101010, 2'b00);
      drive(1'b0, 7'b1010101, 7'b0101010, 2'b01);

      // Reset priority: reset coincides with a non-zero computation,
      // followed by an all-zero OR that must not show the dropped value.
      drive(1'b0, 7'h12, 7'h40, 2'b10);
      drive(1'b1, 7'h7F, 7'h00, 2'b01);
      drive(1'b0, 7'h00, 7'h00, 2'b01);

      // Random operands, rotating op.
      for (int i = 0; i < 40; i++)
         drive(1'b0, W'($urandom_range(0, 127)), W'($urandom_range(0, 127)), rot[i % 4]);

      // Random operands, random op, occasional mid-stream reset.
      for (int i = 0; i < 40; i++)
         drive(($urandom_range(0, 9) == 0), W'($urandom_range(0, 127)),
               W'($urandom_range(0, 127)), 2'($urandom_range(0, 3)));

      // Edge patterns.
      drive(1'b0, 7'h00, 7'h00, 2'b11);
      drive(1'b0, 7'h7F, 7'h55, 2'b11);
      drive(1'b0, 7'h7F, 7'h7F, 2'b10);

      // Drain the scoreboard with a bounded wait.
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      @(negedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending entries required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bitwise_operations

// File: doc/bitwise_operations.md
BITWISE_OPERATIONS -- requirements
Module: bitwise_operations

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 7, SHALL set the operand and result width in bits.
REQ-003 Port clk, input, 1, SHALL be the rising-edge clock for all state.
REQ-004 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port a, input, WIDTH, SHALL be operand A.
REQ-006 Port b, input, WIDTH, SHALL be operand B.
REQ-007 Port op, input, 2, SHALL be the operation select.
REQ-008 Port q, output, WIDTH, SHALL be the registered result.
REQ-009 Port zero, output, 1, SHALL be the registered result-is-zero flag, present only when BITWISE_ZERO_FLAG_EN is defined.

Function
REQ-010 The op encoding SHALL be: 2'b00 = a AND b; 2'b01 = a OR b; 2'b10 = a XOR b; 2'b11 = NOT a, with b ignored.
REQ-011 Each operation SHALL be bitwise across all WIDTH bits, with no carries and no cross-bit interaction.
REQ-012 On each rising clk edge with rst low, q SHALL load f(a, b, op), sampled at that edge.
REQ-013 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on q after edge N and hold until edge N+1.
REQ-014 q SHALL hold its value between edges; no combinational path SHALL exist from a, b or op to q.
REQ-015 An op change at any edge SHALL take effect for that same edge's result; there is no op pipelining or hold-off.
REQ-016 All 4 op codes SHALL be defined, so no X result is possible for known inputs.
REQ-017 Any X or Z on op SHALL produce q = 0 in simulation, as a default branch.
REQ-018 There SHALL be no enable or handshake: a new result is produced every cycle.

Reset
REQ-019 When rst is high at a rising edge, q SHALL become all zeros, and zero (if present) SHALL become 1.
REQ-020 Reset SHALL take priority over computation at the same edge.
REQ-021 The first valid result SHALL appear one edge after rst deasserts.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result, with no memory of prior operands.

Configuration
REQ-023 Macro BITWISE_ZERO_FLAG_EN, when defined, SHALL add output zero, registered alongside q.
REQ-024 With BITWISE_ZERO_FLAG_EN, zero SHALL equal 1 exactly when the value loaded into q is all zeros, with the same one-cycle latency as q.
REQ-025 With BITWISE_ZERO_FLAG_EN undefined, the zero port and its logic SHALL be absent, and q behaviour SHALL be identical to the enabled build.

Structure
REQ-026 A shared package bitwise_ops_pkg SHALL hold the 2-bit op typedef and the named constants OP_AND, OP_OR, OP_XOR and OP_NOT.
REQ-027 The package SHALL also hold the default width constant, value 7.
REQ-028 One combinational sub-module, bitwise_alu_core (a, b, op -> result), SHALL be instantiated.
REQ-029 The top level SHALL contain only the output register(s) and the reset logic.

Verification
REQ-030 Reset: rst=1 for 2 edges with a=7'h7F, b=7'h7F, op=00 -> q=0 and zero=1; first result q=7'h7F appears one edge after rst drops.
REQ-031 Operations: a=1010101, b=0110011, op cycled 00->01->11->10 on successive edges -> q=0010001, 1110111, 0101010, 1100110 respectively, each one cycle after its sample.
REQ-032 Zero flag: a=1010101, b=0101010, op=00 -> q=0000000 and zero=1 next cycle; then op=01 -> q=1111111 and zero=0.
REQ-033 Reset priority: rst=1 at the same edge as a=7'h7F, op=01 -> q=0; no result leaks on the following cycle.
REQ-034 Random run: 20+ cycles of random a and b, with op rotating 00,01,11,10 -> q at every edge matches a reference model of the previous edge's inputs.
